// File: rtl/tm1638_key_reader.sv
// TM1638 key scanner: periodically pushes a read-key transaction to the SPI
// engine, collects the four response bytes and publishes the decoded key state.
module tm1638_key_reader #(
  parameter int POLL_PERIOD = 100000,
  parameter int RX_TIMEOUT  = 4096
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Enable,
  input  logic        i_SPI_FIFO_Full,
  output logic [17:0] o_Data,
  output logic        o_Write,
  input  logic [7:0]  i_Rx_Data,
  input  logic        i_Rx_Valid,
  output logic        o_Rx_Ready,
  output logic [7:0]  o_Keys,
  output logic        o_Keys_Valid,
  output logic        o_Keys_Changed,
  output logic        o_Timeout
);

  localparam logic [17:0] READ_WORD = {2'b10, 8'h04, 8'h42};
  localparam logic [23:0] POLL_LAST = 24'(POLL_PERIOD - 1);
  localparam logic [15:0] RX_LAST   = 16'(RX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_FIFO = 3'd1,
    SEND_READ = 3'd2,
    RECV      = 3'd3,
    PUBLISH   = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [23:0] poll_cnt;
  logic [15:0] rx_wait;
  logic [1:0]  byte_idx;
  logic [3:0]  key_lo, key_hi;
  logic [7:0]  keys_q;
  logic [7:0]  keys_new;
  logic        timeout_q;
  logic        scan_req;
  logic        rx_accept;
  logic        rx_expired;
  logic        rx_unused_bits;

  // Only bit0 and bit4 of each response byte carry key information.
  assign rx_unused_bits = ^{i_Rx_Data[7:5], i_Rx_Data[3:1]};

  assign scan_req   = (poll_cnt == POLL_LAST) && i_Enable;
  assign rx_accept  = i_Rx_Valid && (state == RECV);
  assign rx_expired = (state == RECV) && !rx_accept && (rx_wait == RX_LAST);
  assign keys_new   = {key_hi, key_lo};
  assign o_Timeout  = timeout_q;

  always_ff @(negedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      poll_cnt <= '0;
    end else if (poll_cnt == POLL_LAST) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 24'd1;
    end
  end

  always_ff @(negedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state     <= IDLE;
      rx_wait   <= '0;
      byte_idx  <= '0;
      key_lo    <= '0;
      key_hi    <= '0;
      keys_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      timeout_q <= rx_expired;
      case (state)
        SEND_READ: begin
          byte_idx <= '0;
          rx_wait  <= '0;
        end
        RECV: begin
          if (rx_accept) begin
            key_lo[byte_idx] <= i_Rx_Data[0];
            key_hi[byte_idx] <= i_Rx_Data[4];
            byte_idx         <= byte_idx + 2'd1;
            rx_wait          <= '0;
          end else begin
            rx_wait <= rx_wait + 16'd1;
          end
        end
        PUBLISH: keys_q <= keys_new;
        default: ;
      endcase
    end
  end

  // A FIFO that fills again in the send cycle sends us back to wait, so the
  // push strobe can never coincide with Full.
  always_comb begin
    state_next     = state;
    o_Write        = 1'b0;
    o_Data         = '0;
    o_Rx_Ready     = 1'b0;
    o_Keys         = keys_q;
    o_Keys_Valid   = 1'b0;
    o_Keys_Changed = 1'b0;
    case (state)
      IDLE: begin
        if (scan_req) state_next = WAIT_FIFO;
      end
      WAIT_FIFO: begin
        if (!i_SPI_FIFO_Full) state_next = SEND_READ;
      end
      SEND_READ: begin
        if (i_SPI_FIFO_Full) begin
          state_next = WAIT_FIFO;
        end else begin
          o_Write    = 1'b1;
          o_Data     = READ_WORD;
          state_next = RECV;
        end
      end
      RECV: begin
        o_Rx_Ready = 1'b1;
        if (rx_accept && byte_idx == 2'd3) state_next = PUBLISH;
        else if (rx_expired)               state_next = IDLE;
      end
      PUBLISH: begin
        o_Keys         = keys_new;
        o_Keys_Valid   = 1'b1;
        o_Keys_Changed = (keys_new != keys_q);
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Bench for tm1638_key_reader: directed scans with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_tm1638_key_reader;

  localparam int P = 16;
  localparam int T = 8;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b0;
  logic        i_Enable = 1'b0;
  logic        i_SPI_FIFO_Full = 1'b0;
  logic [7:0]  i_Rx_Data = 8'h00;
  logic        i_Rx_Valid = 1'b0;
  logic [17:0] o_Data;
  logic        o_Write, o_Rx_Ready;
  logic [7:0]  o_Keys;
  logic        o_Keys_Valid, o_Keys_Changed, o_Timeout;

  int checks = 0;
  int errors = 0;
  int tbCycle = 0;

  int obsWrites, obsValids, obsChanged, obsTimeouts, obsAccepted, obsWriteCycle;
  logic [17:0] obsLastData;
  logic [7:0]  obsLastKeys;

  logic [7:0] txQ[$];
  int validPct = 100;
  int fullPct = 0;
  bit randomBytes = 1'b0;

  always #5 i_Clk = ~i_Clk;

  tm1638_key_reader #(.POLL_PERIOD(P), .RX_TIMEOUT(T)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Enable(i_Enable),
    .i_SPI_FIFO_Full(i_SPI_FIFO_Full), .o_Data(o_Data), .o_Write(o_Write),
    .i_Rx_Data(i_Rx_Data), .i_Rx_Valid(i_Rx_Valid), .o_Rx_Ready(o_Rx_Ready),
    .o_Keys(o_Keys), .o_Keys_Valid(o_Keys_Valid),
    .o_Keys_Changed(o_Keys_Changed), .o_Timeout(o_Timeout)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // Key b comes from bit0 of byte b, key b+4 from bit4 of byte b.
  function automatic logic [7:0] mapKeys(input logic [31:0] bytes4);
    int k;
    int v;
    k = 0;
    for (int b = 0; b < 4; b++) begin
      v = int'((bytes4 >> (8 * b)) & 32'hFF);
      k += (v % 2) << b;
      k += ((v / 16) % 2) << (b + 4);
    end
    return k[7:0];
  endfunction

  // Reference model: scan phases tracked as plain integers, response bytes in a queue.
  localparam int M_IDLE = 0, M_WAIT = 1, M_SEND = 2, M_RECV = 3, M_PUB = 4;
  int mPhase = M_IDLE;
  int mCyc = 0;
  int mWait = 0;
  bit mTimeoutNow = 1'b0;
  logic [7:0] mBytes[$];
  logic [7:0] mKeys = 8'h00;

  always @(posedge i_Clk) begin : compare
    logic [30:0] expV, actV;
    logic [7:0]  newKeys;
    logic        sendOk;
    actV = {o_Data, o_Write, o_Rx_Ready, o_Keys, o_Keys_Valid, o_Keys_Changed, o_Timeout};
    if (i_Rst) begin
      mPhase = M_IDLE; mCyc = 0; mWait = 0; mTimeoutNow = 1'b0; mKeys = 8'h00;
      mBytes.delete();
      checkOutput("reset_outputs", 32'(actV), 32'h0);
    end else begin
      newKeys = (mBytes.size() == 4) ?
                mapKeys({mBytes[3], mBytes[2], mBytes[1], mBytes[0]}) : 8'h00;
      sendOk  = (mPhase == M_SEND) && !i_SPI_FIFO_Full;
      expV = {(sendOk ? 18'h20442 : 18'h0), sendOk, (mPhase == M_RECV),
              ((mPhase == M_PUB) ? newKeys : mKeys), (mPhase == M_PUB),
              ((mPhase == M_PUB) && (newKeys != mKeys)), mTimeoutNow};
      checkOutput($sformatf("cycle%0d", tbCycle), 32'(actV), 32'(expV));

      if (o_Write) begin obsWrites++; obsLastData = o_Data; obsWriteCycle = tbCycle; end
      if (o_Keys_Valid) begin obsValids++; obsLastKeys = o_Keys; end
      if (o_Keys_Changed) obsChanged++;
      if (o_Timeout) obsTimeouts++;
      if (i_Rx_Valid && o_Rx_Ready) obsAccepted++;

      mTimeoutNow = 1'b0;
      case (mPhase)
        M_IDLE: if ((mCyc % P) == P - 1 && i_Enable) mPhase = M_WAIT;
        M_WAIT: if (!i_SPI_FIFO_Full) mPhase = M_SEND;
        M_SEND: begin
          if (i_SPI_FIFO_Full) mPhase = M_WAIT;
          else begin mBytes.delete(); mWait = 0; mPhase = M_RECV; end
        end
        M_RECV: begin
          if (i_Rx_Valid) begin
            mBytes.push_back(i_Rx_Data);
            mWait = 0;
            if (mBytes.size() == 4) mPhase = M_PUB;
          end else if (mWait == T - 1) begin
            mTimeoutNow = 1'b1;
            mPhase = M_IDLE;
          end else begin
            mWait++;
          end
        end
        M_PUB: begin mKeys = newKeys; mPhase = M_IDLE; end
        default: mPhase = M_IDLE;
      endcase
      mCyc++;
    end
    tbCycle++;
  end

  task automatic applyStimulus(input int n);
    logic acc;
    repeat (n) begin
      @(posedge i_Clk);
      acc = i_Rx_Valid && o_Rx_Ready;
      @(negedge i_Clk);
      #1;
      if (acc && txQ.size() > 0) void'(txQ.pop_front());
      i_SPI_FIFO_Full = (int'($urandom_range(99)) < fullPct);
      if (txQ.size() > 0) begin
        i_Rx_Valid = (int'($urandom_range(99)) < validPct);
        i_Rx_Data  = txQ[0];
      end else if (randomBytes) begin
        i_Rx_Valid = (int'($urandom_range(99)) < validPct);
        i_Rx_Data  = 8'($urandom);
      end else begin
        i_Rx_Valid = 1'b0;
        i_Rx_Data  = 8'h00;
      end
    end
  endtask

  task automatic clearObs();
    obsWrites = 0; obsValids = 0; obsChanged = 0; obsTimeouts = 0;
    obsAccepted = 0; obsWriteCycle = -1; obsLastData = '0; obsLastKeys = '0;
  endtask

  task automatic waitScan(input string name);
    int start;
    int n;
    start = obsValids + obsTimeouts;
    n = 0;
    while (obsValids + obsTimeouts == start && n < 80) begin
      applyStimulus(1);
      n++;
    end
    checkOutput({name, "_finished"}, 32'(obsValids + obsTimeouts != start), 32'd1);
  endtask

  initial begin : main
    int relCycle;
    int fallCycle;
    int n;
    clearObs();
    #1 i_Rst = 1'b1;
    applyStimulus(3);
    #2;
    checkOutput("reset_keys", 32'(o_Keys), 32'h0);
    checkOutput("reset_data", 32'(o_Data), 32'h0);
    checkOutput("reset_strobes",
                32'({o_Write, o_Rx_Ready, o_Keys_Valid, o_Keys_Changed, o_Timeout}), 32'h0);

    // First scan after release: bytes 01,10,00,11.
    i_Enable = 1'b1;
    txQ = '{8'h01, 8'h10, 8'h00, 8'h11};
    relCycle = tbCycle;
    i_Rst = 1'b0;
    waitScan("scan1");
    checkOutput("scan1_writes", 32'(obsWrites), 32'd1);
    checkOutput("scan1_data", 32'(obsLastData), 32'h20442);
    checkOutput("scan1_first_write_cycle", 32'(obsWriteCycle - relCycle), 32'(P + 1));
    checkOutput("scan1_valids", 32'(obsValids), 32'd1);
    checkOutput("scan1_changed", 32'(obsChanged), 32'd1);
    checkOutput("scan1_keys", 32'(obsLastKeys), 32'hA9);
    checkOutput("scan1_keys_held", 32'(o_Keys), 32'hA9);

    // Same bytes again: valid but unchanged.
    clearObs();
    txQ = '{8'h01, 8'h10, 8'h00, 8'h11};
    waitScan("scan2");
    checkOutput("scan2_valids", 32'(obsValids), 32'd1);
    checkOutput("scan2_changed", 32'(obsChanged), 32'd0);
    checkOutput("scan2_keys", 32'(o_Keys), 32'hA9);

    // FIFO full across the scan start.
    clearObs();
    fullPct = 100;
    applyStimulus(20);
    checkOutput("fifo_full_no_write", 32'(obsWrites), 32'd0);
    txQ = '{8'h01, 8'h10, 8'h00, 8'h11};
    fullPct = 0;
    i_SPI_FIFO_Full = 1'b0;
    fallCycle = tbCycle;
    waitScan("fifo");
    checkOutput("fifo_writes", 32'(obsWrites), 32'd1);
    checkOutput("fifo_write_cycle", 32'(obsWriteCycle - fallCycle), 32'd1);

    // Only two bytes: timeout, then a normal scan.
    clearObs();
    txQ = '{8'h11, 8'h11};
    waitScan("timeout");
    checkOutput("timeout_pulses", 32'(obsTimeouts), 32'd1);
    checkOutput("timeout_no_valid", 32'(obsValids), 32'd0);
    checkOutput("timeout_keys", 32'(o_Keys), 32'hA9);
    clearObs();
    txQ = '{8'h00, 8'h11, 8'h10, 8'h01};
    waitScan("after_timeout");
    checkOutput("after_timeout_valids", 32'(obsValids), 32'd1);
    checkOutput("after_timeout_keys", 32'(o_Keys), 32'h6A);
    checkOutput("after_timeout_changed", 32'(obsChanged), 32'd1);

    // Six bytes offered with valid held high: only four consumed.
    clearObs();
    txQ = '{8'h01, 8'h01, 8'h01, 8'h01, 8'hFF, 8'hFF};
    waitScan("overfeed");
    checkOutput("overfeed_accepted", 32'(obsAccepted), 32'd4);
    checkOutput("overfeed_left", 32'(txQ.size()), 32'd2);
    checkOutput("overfeed_keys", 32'(o_Keys), 32'h0F);
    txQ.delete();

    // Reset in the middle of a scan.
    clearObs();
    txQ = '{8'h01, 8'h01, 8'h01, 8'h01};
    n = 0;
    while (obsAccepted < 2 && n < 80) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("midreset_two_bytes", 32'(obsAccepted), 32'd2);
    #1 i_Rst = 1'b1;
    #1;
    checkOutput("midreset_keys", 32'(o_Keys), 32'h0);
    checkOutput("midreset_strobes",
                32'({o_Data, o_Write, o_Rx_Ready, o_Keys_Valid, o_Keys_Changed, o_Timeout}), 32'h0);
    applyStimulus(2);
    txQ.delete();
    clearObs();
    i_Rst = 1'b0;
    applyStimulus(P + 1);
    checkOutput("post_reset_quiet",
                32'(obsWrites + obsValids + obsChanged + obsTimeouts), 32'd0);
    applyStimulus(1);
    checkOutput("post_reset_first_write", 32'(obsWrites), 32'd1);
    txQ = '{8'h10, 8'h10, 8'h10, 8'h10};
    waitScan("post_reset");
    checkOutput("post_reset_keys", 32'(o_Keys), 32'hF0);

    // Randomized traffic, including occasional resets and enable toggling.
    randomBytes = 1'b1;
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(3))
        0: validPct = 0;
        1: validPct = 30;
        2: validPct = 70;
        default: validPct = 100;
      endcase
      case ($urandom_range(2))
        0: fullPct = 0;
        1: fullPct = 20;
        default: fullPct = 60;
      endcase
      i_Enable = ($urandom_range(3) != 0);
      if (seg % 10 == 9) begin
        i_Rst = 1'b1;
        applyStimulus(2);
        i_Rst = 1'b0;
      end
      applyStimulus(40);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
